// File: rtl/cam_stream_gen_if.sv
// Video bus from the camera-side generator to a capture block: vsync/href framing,
// 8-bit pixel bytes and per-frame bookkeeping.
interface cam_stream_gen_if;
    // No valid/ready: href high means o_data carries a pixel byte that cycle.
    // There is no backpressure, so the receiver must accept every href byte.
    logic        o_vsync;
    logic        o_href;
    logic [7:0]  o_data;
    logic        o_frame_done;
    logic [15:0] o_frame_cnt;

    modport master (
        output o_vsync,
        output o_href,
        output o_data,
        output o_frame_done,
        output o_frame_cnt
    );

    modport slave (
        input o_vsync,
        input o_href,
        input o_data,
        input o_frame_done,
        input o_frame_cnt
    );
endinterface

// File: rtl/cam_stream_gen.sv
// Camera-side RGB444 frame generator (counter, colour bars, solid, optional LFSR).
// Define CAMGEN_LFSR_EN to build the mode-3 LFSR; otherwise mode 3 is the counter pattern.
module cam_stream_gen #(
    parameter int ROWLENGTH   = 640,
    parameter int ROWCOUNT    = 480,
    parameter int VSYNC_CLKS  = 4704,
    parameter int VBP_CLKS    = 26656,
    parameter int HBLANK_CLKS = 288,
    parameter int VFP_CLKS    = 7840
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [11:0]      i_solid,
    cam_stream_gen_if.master vid,
    output logic [2:0]       o_dbg_state
);
    localparam int LINE_BYTES = 2 * ROWLENGTH;
    localparam int MAX_A   = (VSYNC_CLKS > VBP_CLKS) ? VSYNC_CLKS : VBP_CLKS;
    localparam int MAX_B   = (HBLANK_CLKS > VFP_CLKS) ? HBLANK_CLKS : VFP_CLKS;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_ALL = (MAX_AB > LINE_BYTES) ? MAX_AB : LINE_BYTES;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);
    localparam int ROW_W   = $clog2(ROWCOUNT + 1);
    localparam int COL_W   = $clog2(ROWLENGTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_ACTIVE = 3'd3,
        S_HBLANK = 3'd4,
        S_VFP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [11:0]        pix_cnt_q, pix_cnt_d;
    logic [7:0]         lo_q, lo_d;
    logic [1:0]         mode_q, mode_d;
    logic [11:0]        solid_q, solid_d;
    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               frame_start;
    logic [11:0]        pix_now;
    logic [11:0]        bar_rgb;
    logic [2:0]         bar;
    int                 col8;
`ifdef CAMGEN_LFSR_EN
    logic [11:0]        lfsr_q, lfsr_d;
`endif

    // Bar index = floor(col*8/ROWLENGTH), found by comparing against the constant boundaries.
    always_comb begin
        col8 = int'(col_q) << 3;
        bar  = 3'd0;
        for (int b = 1; b < 8; b++) begin
            if (col8 >= b * ROWLENGTH) bar = bar + 3'd1;
        end
        case (bar)
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    always_comb begin
        case (mode_q)
            2'd1:    pix_now = bar_rgb;
            2'd2:    pix_now = solid_q;
`ifdef CAMGEN_LFSR_EN
            2'd3:    pix_now = lfsr_q;
`endif
            default: pix_now = pix_cnt_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        pix_cnt_d   = pix_cnt_q;
        lo_d        = lo_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        frame_start = 1'b0;
`ifdef CAMGEN_LFSR_EN
        lfsr_d      = lfsr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_en) frame_start = 1'b1;
            end
            S_VSYNC: begin
                if (cnt_q == CNT_W'(VSYNC_CLKS - 1)) begin
                    state_d = S_VBP;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_VBP: begin
                if (cnt_q == CNT_W'(VBP_CLKS - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_ACTIVE: begin
                if (cnt_q == CNT_W'(LINE_BYTES - 1)) begin
                    cnt_d = '0;
                    col_d = '0;
                    if (row_q == ROW_W'(ROWCOUNT - 1)) begin
                        state_d = S_VFP;
                        row_d   = '0;
                    end else begin
                        state_d = S_HBLANK;
                        row_d   = row_q + 1'b1;
                    end
                end else cnt_d = cnt_q + 1'b1;
            end
            S_HBLANK: begin
                if (cnt_q == CNT_W'(HBLANK_CLKS - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_VFP: begin
                if (cnt_q == CNT_W'(VFP_CLKS - 1)) begin
                    cnt_d = '0;
                    if (i_en) frame_start = 1'b1;
                    else      state_d     = S_IDLE;
                end else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Mode and solid colour are only sampled here, so mid-frame changes wait for the next frame.
        if (frame_start) begin
            state_d   = S_VSYNC;
            cnt_d     = '0;
            row_d     = '0;
            col_d     = '0;
            pix_cnt_d = '0;
            mode_d    = i_mode;
            solid_d   = i_solid;
`ifdef CAMGEN_LFSR_EN
            lfsr_d    = 12'hACE;
`endif
        end

        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE);
        data_d  = 8'h00;
        if (href_d) data_d = cnt_d[0] ? lo_q : {4'hF, pix_now[11:8]};

        // A new pixel is taken on every even byte; its low byte is held for the odd byte.
        if (href_d && !cnt_d[0]) begin
            lo_d      = pix_now[7:0];
            pix_cnt_d = pix_cnt_q + 12'd1;
            col_d     = col_q + 1'b1;
`ifdef CAMGEN_LFSR_EN
            lfsr_d    = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};
`endif
        end

        done_d      = href_d && (cnt_d == CNT_W'(LINE_BYTES - 1)) && (row_d == ROW_W'(ROWCOUNT - 1));
        frame_cnt_d = frame_cnt_q + 16'(done_d);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pix_cnt_q   <= '0;
            lo_q        <= '0;
            mode_q      <= '0;
            solid_q     <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef CAMGEN_LFSR_EN
            lfsr_q      <= 12'hACE;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pix_cnt_q   <= pix_cnt_d;
            lo_q        <= lo_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            vsync_q     <= vsync_d;
            href_q      <= href_d;
            data_q      <= data_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef CAMGEN_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign vid.o_vsync      = vsync_q;
    assign vid.o_href       = href_q;
    assign vid.o_data       = data_q;
    assign vid.o_frame_done = done_q;
    assign vid.o_frame_cnt  = frame_cnt_q;
    assign o_dbg_state      = state_q;
endmodule
